// File: rtl/poly_mult_pkg.sv
// Shared types and default sizing for the polynomial multiply engine.
// Configuration macro: POLY_MULT_RING_REDUCE_EN enables folding modulo x^P - x - 1.
package poly_mult_pkg;

  localparam int unsigned POLY_P_DEF     = 761;
  localparam int unsigned POLY_A_W_DEF   = 13;
  localparam int unsigned POLY_B_W_DEF   = 13;
  localparam int unsigned POLY_ACC_W_DEF = 26;
  localparam int unsigned STATE_W        = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_CLR     = 4'd1,
    ST_MAC_RD  = 4'd2,
    ST_MAC_WR  = 4'd3,
    ST_FOLD_H  = 4'd4,
    ST_FOLD_L0 = 4'd5,
    ST_FOLD_W0 = 4'd6,
    ST_FOLD_W1 = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

endpackage

// File: rtl/poly_mult_idx_cnt.sv
// Loop indices for the engine: i/j walk the MAC grid, k walks the C array.
// Configuration macro: POLY_MULT_RING_REDUCE_EN (k_load_top/k_dec used only then).
module poly_mult_idx_cnt
  import poly_mult_pkg::*;
#(
  parameter int unsigned P      = 4,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ij_clr,
  input  logic              ij_inc,
  input  logic              k_clr,
  input  logic              k_inc,
  input  logic              k_load_top,
  input  logic              k_dec,
  output logic [ADDR_W-1:0] i,
  output logic [ADDR_W-1:0] j,
  output logic [ADDR_W-1:0] k,
  output logic              j_wrap_c,
  output logic              ij_wrap_c,
  output logic              k_top_c
);

  localparam logic [ADDR_W-1:0] LAST_IJ = ADDR_W'(P - 1);
  localparam logic [ADDR_W-1:0] K_TOP   = ADDR_W'(2 * P - 2);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  // Terminal-count flags
  assign j_wrap_c  = (j == LAST_IJ);
  assign ij_wrap_c = j_wrap_c && (i == LAST_IJ);
  assign k_top_c   = (k == K_TOP);

  // i/j row-major walk, k clear/load/step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
    end else begin
      if (ij_clr) begin
        i <= '0;
        j <= '0;
      end else if (ij_inc) begin
        if (j_wrap_c) begin
          j <= '0;
          i <= i + ONE;
        end else begin
          j <= j + ONE;
        end
      end
      if (k_clr) begin
        k <= '0;
      end else if (k_load_top) begin
        k <= K_TOP;
      end else if (k_inc) begin
        k <= k + ONE;
      end else if (k_dec) begin
        k <= k - ONE;
      end
    end
  end

endmodule

// File: rtl/poly_mult_engine.sv
// Schoolbook polynomial multiplier over external A/B/C memories:
// C[k] = sum A[i]*B[j] (i+j=k), mod 2^ACC_W, one read-modify-write per MAC.
// Configuration macro: POLY_MULT_RING_REDUCE_EN folds C modulo x^P - x - 1.
module poly_mult_engine
  import poly_mult_pkg::*;
#(
  parameter  int unsigned P      = POLY_P_DEF,
  parameter  int unsigned A_W    = POLY_A_W_DEF,
  parameter  int unsigned B_W    = POLY_B_W_DEF,
  parameter  int unsigned ACC_W  = POLY_ACC_W_DEF,
  localparam int unsigned ADDR_W = $clog2(2 * P - 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] a_addr,
  input  logic [A_W-1:0]    a_rdata,
  output logic [ADDR_W-1:0] b_addr,
  input  logic [B_W-1:0]    b_rdata,
  output logic [ADDR_W-1:0] c_raddr,
  input  logic [ACC_W-1:0]  c_rdata,
  output logic [ADDR_W-1:0] c_waddr,
  output logic [ACC_W-1:0]  c_wdata,
  output logic              c_we
);

  localparam int unsigned       PROD_W = A_W + B_W;
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
`ifdef POLY_MULT_RING_REDUCE_EN
  localparam logic [ADDR_W-1:0] K_TOP  = ADDR_W'(2 * P - 2);
  localparam logic [ADDR_W-1:0] P_A    = ADDR_W'(P);
  localparam logic [ADDR_W-1:0] P_M1_A = ADDR_W'(P - 1);
`endif

  state_e              state, state_nxt;
  logic [ADDR_W-1:0]   i, j, k;
  logic [ADDR_W-1:0]   i_nx_c, j_nx_c;
  logic                j_wrap_c, ij_wrap_c, k_top_c;
  logic                ij_clr, ij_inc, k_clr, k_inc, k_load_top, k_dec;
  logic                busy_d, done_d, c_we_d;
  logic [ADDR_W-1:0]   a_addr_d, b_addr_d, c_raddr_d, c_waddr_d;
  logic [PROD_W-1:0]   prod_c;
`ifdef POLY_MULT_RING_REDUCE_EN
  logic [ACC_W-1:0]    hi;
  logic                hi_ld;
`endif

  poly_mult_idx_cnt #(
    .P      (P),
    .ADDR_W (ADDR_W)
  ) u_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .ij_clr     (ij_clr),
    .ij_inc     (ij_inc),
    .k_clr      (k_clr),
    .k_inc      (k_inc),
    .k_load_top (k_load_top),
    .k_dec      (k_dec),
    .i          (i),
    .j          (j),
    .k          (k),
    .j_wrap_c   (j_wrap_c),
    .ij_wrap_c  (ij_wrap_c),
    .k_top_c    (k_top_c)
  );

  // Indices of the MAC following the current one
  assign i_nx_c = j_wrap_c ? i + ONE : i;
  assign j_nx_c = j_wrap_c ? '0 : j + ONE;

  assign prod_c = PROD_W'(a_rdata) * PROD_W'(b_rdata);

  // Write data depends on read data returned this cycle, so it is not registered
  always_comb begin
    c_wdata = '0;
    case (state)
      ST_MAC_WR:  c_wdata = c_rdata + ACC_W'(prod_c);
`ifdef POLY_MULT_RING_REDUCE_EN
      ST_FOLD_W0,
      ST_FOLD_W1: c_wdata = c_rdata + hi;
`endif
      default:    c_wdata = '0;
    endcase
  end

  // Next state, counter controls and next-cycle values of registered outputs
  always_comb begin
    state_nxt  = state;
    ij_clr     = 1'b0;
    ij_inc     = 1'b0;
    k_clr      = 1'b0;
    k_inc      = 1'b0;
    k_load_top = 1'b0;
    k_dec      = 1'b0;
    c_we_d     = 1'b0;
    a_addr_d   = a_addr;
    b_addr_d   = b_addr;
    c_raddr_d  = c_raddr;
    c_waddr_d  = c_waddr;
`ifdef POLY_MULT_RING_REDUCE_EN
    hi_ld      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_CLR;
          k_clr     = 1'b1;
          c_waddr_d = '0;
          c_we_d    = 1'b1;
        end
      end
      ST_CLR: begin
        if (k_top_c) begin
          state_nxt = ST_MAC_RD;
          ij_clr    = 1'b1;
          a_addr_d  = '0;
          b_addr_d  = '0;
          c_raddr_d = '0;
        end else begin
          k_inc     = 1'b1;
          c_waddr_d = k + ONE;
          c_we_d    = 1'b1;
        end
      end
      ST_MAC_RD: begin
        state_nxt = ST_MAC_WR;
        c_waddr_d = i + j;
        c_we_d    = 1'b1;
      end
      ST_MAC_WR: begin
        if (ij_wrap_c) begin
`ifdef POLY_MULT_RING_REDUCE_EN
          state_nxt  = ST_FOLD_H;
          k_load_top = 1'b1;
          c_raddr_d  = K_TOP;
`else
          state_nxt  = ST_DONE;
`endif
        end else begin
          state_nxt = ST_MAC_RD;
          ij_inc    = 1'b1;
          a_addr_d  = i_nx_c;
          b_addr_d  = j_nx_c;
          c_raddr_d = i_nx_c + j_nx_c;
        end
      end
`ifdef POLY_MULT_RING_REDUCE_EN
      ST_FOLD_H: begin
        state_nxt = ST_FOLD_L0;
        c_raddr_d = k - P_A;
      end
      ST_FOLD_L0: begin
        state_nxt = ST_FOLD_W0;
        hi_ld     = 1'b1;
        c_raddr_d = k - P_M1_A;
        c_waddr_d = k - P_A;
        c_we_d    = 1'b1;
      end
      ST_FOLD_W0: begin
        state_nxt = ST_FOLD_W1;
        c_waddr_d = k - P_M1_A;
        c_we_d    = 1'b1;
      end
      ST_FOLD_W1: begin
        if (k == P_A) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_FOLD_H;
          k_dec     = 1'b1;
          c_raddr_d = k - ONE;
        end
      end
`endif
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_d = (state_nxt != ST_IDLE);
    done_d = (state_nxt == ST_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      c_we    <= 1'b0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_raddr <= '0;
      c_waddr <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= busy_d;
      done    <= done_d;
      c_we    <= c_we_d;
      a_addr  <= a_addr_d;
      b_addr  <= b_addr_d;
      c_raddr <= c_raddr_d;
      c_waddr <= c_waddr_d;
    end
  end

`ifdef POLY_MULT_RING_REDUCE_EN
  // Coefficient being folded, captured as C[k] returns
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi <= '0;
    end else if (hi_ld) begin
      hi <= c_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_poly_mult_engine.sv
// Self-checking bench for poly_mult_engine: directed vectors plus random
// operands against a schoolbook reference model. Honours POLY_MULT_RING_REDUCE_EN.
module tb_poly_mult_engine;

  logic clk;
  logic rst_n;

  // DUT0: P=4, 16-bit accumulator (truncation visible)
  logic        start0, busy0, done0, c_we0;
  logic [2:0]  a_addr0, b_addr0, c_raddr0, c_waddr0;
  logic [12:0] a_rdata0, b_rdata0;
  logic [15:0] c_rdata0, c_wdata0;
  logic [12:0] amem0 [8];
  logic [12:0] bmem0 [8];
  logic [15:0] cmem0 [8];

  // DUT1: P=13, default widths
  logic        start1, busy1, done1, c_we1;
  logic [4:0]  a_addr1, b_addr1, c_raddr1, c_waddr1;
  logic [12:0] a_rdata1, b_rdata1;
  logic [25:0] c_rdata1, c_wdata1;
  logic [12:0] amem1 [32];
  logic [12:0] bmem1 [32];
  logic [25:0] cmem1 [32];

  int vectors;
  int miscompares;
  longint unsigned exp_c[$];

  poly_mult_engine #(.P(4), .A_W(13), .B_W(13), .ACC_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .a_addr(a_addr0), .a_rdata(a_rdata0), .b_addr(b_addr0), .b_rdata(b_rdata0),
    .c_raddr(c_raddr0), .c_rdata(c_rdata0), .c_waddr(c_waddr0),
    .c_wdata(c_wdata0), .c_we(c_we0)
  );

  poly_mult_engine #(.P(13), .A_W(13), .B_W(13), .ACC_W(26)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .a_addr(a_addr1), .a_rdata(a_rdata1), .b_addr(b_addr1), .b_rdata(b_rdata1),
    .c_raddr(c_raddr1), .c_rdata(c_rdata1), .c_waddr(c_waddr1),
    .c_wdata(c_wdata1), .c_we(c_we1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories; a write is visible to reads at later edges
  always @(posedge clk) begin
    a_rdata0 <= amem0[a_addr0];
    b_rdata0 <= bmem0[b_addr0];
    c_rdata0 <= cmem0[c_raddr0];
    if (c_we0) cmem0[c_waddr0] <= c_wdata0;
    a_rdata1 <= amem1[a_addr1];
    b_rdata1 <= bmem1[b_addr1];
    c_rdata1 <= cmem1[c_raddr1];
    if (c_we1) cmem1[c_waddr1] <= c_wdata1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Product ring: plain schoolbook sum, optional reduction by x^p = x + 1
  task automatic model(input int p, input int acc_w,
                       input longint unsigned a[$], input longint unsigned b[$]);
    longint unsigned c[$];
    longint unsigned mask;
    int n_res;
    mask = (64'd1 << acc_w) - 64'd1;
    c = {};
    for (int k = 0; k < 2 * p - 1; k++) c.push_back(0);
    for (int i = 0; i < p; i++)
      for (int j = 0; j < p; j++)
        c[i + j] += a[i] * b[j];
`ifdef POLY_MULT_RING_REDUCE_EN
    for (int k = 2 * p - 2; k >= p; k--) begin
      c[k - p]     += c[k];
      c[k - p + 1] += c[k];
      c[k]          = 0;
    end
    n_res = p;
`else
    n_res = 2 * p - 1;
`endif
    exp_c = {};
    for (int k = 0; k < n_res; k++) exp_c.push_back(c[k] & mask);
  endtask

  // Cycles from busy rising to the done pulse
  function automatic int exp_busy(input int p);
`ifdef POLY_MULT_RING_REDUCE_EN
    return (2 * p - 1) + 2 * p * p + 4 * (p - 1);
`else
    return (2 * p - 1) + 2 * p * p;
`endif
  endfunction

  task automatic load(input int sel, input int p,
                      input longint unsigned a[$], input longint unsigned b[$]);
    for (int i = 0; i < p; i++) begin
      if (sel == 0) begin
        amem0[i] = 13'(a[i]);
        bmem0[i] = 13'(b[i]);
      end else begin
        amem1[i] = 13'(a[i]);
        bmem1[i] = 13'(b[i]);
      end
    end
  endtask

  function automatic logic [63:0] get_c(input int sel, input int idx);
    if (sel == 0) return 64'(cmem0[3'(idx)]);
    return 64'(cmem1[5'(idx)]);
  endfunction

  function automatic logic cur_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction

  function automatic logic cur_done(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  // One operation; optional extra start pulse at cycle pulse_at (-1 for none)
  task automatic run(input int sel, input int pulse_at,
                     output int busy_cyc, output int done_cnt);
    int after;
    busy_cyc = 0;
    done_cnt = 0;
    after    = -1;
    @(negedge clk); set_start(sel, 1'b1);
    @(negedge clk); set_start(sel, 1'b0);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cur_busy(sel) && !cur_done(sel)) busy_cyc++;
      if (cur_done(sel)) begin
        done_cnt++;
        if (after < 0) after = 0;
      end
      if (after >= 0) begin
        if (after == 3) break;
        after++;
      end
      set_start(sel, logic'(cyc == pulse_at));
      @(negedge clk);
    end
    set_start(sel, 1'b0);
  endtask

  task automatic run_and_check(input string tag, input int sel, input int p,
                               input longint unsigned a[$], input longint unsigned b[$],
                               input longint unsigned exp[$], input int exp_cyc,
                               input int pulse_at);
    int busy_cyc, done_cnt;
    load(sel, p, a, b);
    run(sel, pulse_at, busy_cyc, done_cnt);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_cyc));
    for (int k = 0; k < exp.size(); k++)
      check($sformatf("%s_c%0d", tag, k), get_c(sel, k), 64'(exp[k]));
  endtask

  initial begin
    longint unsigned dir_a[$], dir_b[$], dir_exp[$];
    longint unsigned sat_a[$], sat_exp[$];
    longint unsigned ra[$], rb[$];
    int dir_cyc;

    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 8; i++)  begin amem0[i] = '0; bmem0[i] = '0; end
    for (int i = 0; i < 32; i++) begin amem1[i] = '0; bmem1[i] = '0; end

    dir_a = '{1, 2, 0, 0};
    dir_b = '{3, 0, 0, 1};
    sat_a = '{255, 255, 0, 0};
`ifdef POLY_MULT_RING_REDUCE_EN
    dir_exp = '{5, 8, 0, 1};
    sat_exp = '{65025, 64514, 65025, 0};
    dir_cyc = 51;
`else
    dir_exp = '{3, 6, 0, 1, 2, 0, 0};
    sat_exp = '{65025, 64514, 65025, 0, 0, 0, 0};
    dir_cyc = 39;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy0",    64'(busy0),    64'd0);
    check("rst_done0",    64'(done0),    64'd0);
    check("rst_we0",      64'(c_we0),    64'd0);
    check("rst_a_addr0",  64'(a_addr0),  64'd0);
    check("rst_b_addr0",  64'(b_addr0),  64'd0);
    check("rst_c_raddr0", 64'(c_raddr0), 64'd0);
    check("rst_c_waddr0", 64'(c_waddr0), 64'd0);
    check("rst_busy1",    64'(busy1),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small known product
    run_and_check("dir", 0, 4, dir_a, dir_b, dir_exp, dir_cyc, -1);

    // Accumulator wrap at 16 bits
    run_and_check("wrap", 0, 4, sat_a, sat_a, sat_exp, dir_cyc, -1);

    // start during MAC must be ignored
    run_and_check("restart", 0, 4, dir_a, dir_b, dir_exp, dir_cyc, 15);

    // Reset in the middle of MAC
    load(0, 4, sat_a, dir_b);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", 64'(busy0), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy",    64'(busy0),    64'd0);
    check("mrst_done",    64'(done0),    64'd0);
    check("mrst_we",      64'(c_we0),    64'd0);
    check("mrst_a_addr",  64'(a_addr0),  64'd0);
    check("mrst_c_waddr", 64'(c_waddr0), 64'd0);
    @(negedge clk);
    check("post_rst_we",   64'(c_we0), 64'd0);
    check("post_rst_busy", 64'(busy0), 64'd0);
    run_and_check("after_rst", 0, 4, dir_a, dir_b, dir_exp, dir_cyc, -1);

    // Random operands, 16-bit accumulator
    for (int r = 0; r < 4; r++) begin
      ra = {}; rb = {};
      for (int i = 0; i < 4; i++) begin
        ra.push_back(longint'($urandom_range(0, 8191)));
        rb.push_back(longint'($urandom_range(0, 8191)));
      end
      model(4, 16, ra, rb);
      run_and_check($sformatf("rnd4_%0d", r), 0, 4, ra, rb, exp_c, exp_busy(4), -1);
    end

    // Random operands, P=13, default widths
    for (int r = 0; r < 2; r++) begin
      ra = {}; rb = {};
      for (int i = 0; i < 13; i++) begin
        ra.push_back(longint'($urandom_range(0, 8191)));
        rb.push_back(longint'($urandom_range(0, 8191)));
      end
      model(13, 26, ra, rb);
      run_and_check($sformatf("rnd13_%0d", r), 1, 13, ra, rb, exp_c, exp_busy(13), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/poly_mult_engine.md
POLY_MULT_ENGINE -- requirements
Module: poly_mult_engine

Interface
REQ-001 SHALL have parameter P, default 761, the number of coefficients per operand polynomial.
REQ-002 SHALL have parameter A_W, default 13, the operand-A coefficient width, unsigned.
REQ-003 SHALL have parameter B_W, default 13, the operand-B coefficient width, unsigned.
REQ-004 SHALL have parameter ACC_W, default 26, the result coefficient width; ADDR_W = $clog2(2P-1) is derived, not settable.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, the reset: synchronous and active-low.
REQ-007 SHALL have ports start (input, 1, begin request), busy (output, 1, operation in progress) and done (output, 1, one-cycle completion pulse).
REQ-008 SHALL have ports a_addr (output, ADDR_W) with a_rdata (input, A_W), and b_addr (output, ADDR_W) with b_rdata (input, B_W); both read ports have 1-cycle synchronous-read latency.
REQ-009 SHALL have C-memory ports c_raddr (output, ADDR_W), c_rdata (input, ACC_W, 1-cycle latency), c_waddr (output, ADDR_W), c_wdata (output, ACC_W) and c_we (output, 1).

Function
REQ-010 SHALL compute C[k] = sum over i+j=k of A[i]*B[j], for i,j in 0..P-1, unsigned, mod 2^ACC_W; the product is zero-extended or truncated to ACC_W.
REQ-011 SHALL implement states IDLE, CLR, MAC_RD, MAC_WR, FOLD_H, FOLD_L0, FOLD_W0, FOLD_W1 and DONE.
REQ-012 IDLE: start=1 moves to CLR next cycle; start is ignored in every other state.
REQ-013 CLR: writes 0 to C[0..2P-2], one address per cycle ascending, 2P-1 cycles, then MAC_RD with i=j=0.
REQ-014 MAC_RD: drives a_addr=i, b_addr=j, c_raddr=i+j, c_we=0.
REQ-015 MAC_WR: drives c_waddr=i+j, c_wdata=c_rdata+a_rdata*b_rdata and c_we=1, then increments j; on j=P-1, j clears and i increments; after i=j=P-1 it leaves MAC.
REQ-016 Each MAC costs exactly 2 cycles, so the MAC phase takes 2*P*P cycles.
REQ-017 The C memory SHALL return newly written data on a read issued in any cycle after the write.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 done SHALL be 1 for exactly one cycle, in DONE, then return to IDLE.
REQ-020 Addresses are held, and c_we=0, in every non-writing state.

Reset
REQ-021 rst_n=0 at a clock edge SHALL force IDLE and clear busy, done, c_we, i, j, k and all address outputs to 0, including mid-operation.
REQ-022 A reset mid-operation SHALL NOT repair partial C contents, and no write may occur in the cycle after reset.

Configuration
REQ-023 Macro POLY_MULT_RING_REDUCE_EN defined: after MAC, fold C modulo x^P - x - 1 for k = 2P-2 down to P.
REQ-024 Each fold takes 4 cycles: FOLD_H reads C[k]; FOLD_L0 latches hi and reads C[k-P]; FOLD_W0 writes C[k-P]+hi and reads C[k-P+1]; FOLD_W1 writes C[k-P+1]+hi.
REQ-025 With the macro defined, the fold phase takes 4*(P-1) cycles, the result is C[0..P-1], and C[P..2P-2] is unspecified.
REQ-026 Macro undefined: the FOLD states and hi register are not compiled, MAC goes directly to DONE, and the result is C[0..2P-2].

Structure
REQ-027 Package poly_mult_pkg SHALL hold the state enum typedef and the default P, A_W, B_W and ACC_W constants.
REQ-028 Sub-module poly_mult_idx_cnt SHALL hold the i/j/k counters, with clear, increment and wrap flags.
REQ-029 The FSM and arithmetic SHALL reside in poly_mult_engine.

Verification
REQ-030 P=4, A=[1,2,0,0], B=[3,0,0,1], macro undefined -> C=[3,6,0,1,2,0,0]; busy high for 39 cycles; done pulses once.
REQ-031 Same stimulus, macro defined -> C[0..3]=[5,8,0,1]; busy high for 51 cycles.
REQ-032 P=4, ACC_W=16, A=B=[255,255,0,0] -> C[0]=65025, C[1]=64514 (wrapped), C[2]=65025.
REQ-033 start pulsed while busy in MAC -> no restart; result and cycle count unchanged.
REQ-034 rst_n low for 1 cycle mid-MAC -> next cycle IDLE with busy=0 and c_we=0; a following start yields a correct result.
REQ-035 Randomised A/B with P=761 and default widths -> C matches a software schoolbook model, with and without the macro.
